// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus between the hazard/decode side and the PC sequencer.
// master drives stall/redirect/memory-ready; slave is the sequencer itself.
interface pc_fetch_ctrl_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        fetch_valid;
  logic        if_flush;
  logic [31:0] fetch_count;
  logic        misalign_err;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, imem_ready,
    input  pc_out, pc_plus4, imem_req, fetch_valid, if_flush, fetch_count, misalign_err
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_ready,
    output pc_out, pc_plus4, imem_req, fetch_valid, if_flush, fetch_count, misalign_err
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: sequential/branch/jump next-PC select, stall hold, redirect buffering.
// Optional PC_ALIGN_CHECK_EN: drop misaligned redirects and flag them in a sticky misalign_err.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clock,
  input logic           reset,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic        run;
  logic        redir_req;
  logic        redir;
  logic [31:0] raw_target;
  logic [31:0] redir_target;
  logic        accept;
  logic [31:0] next_pc;

  logic [31:0] pc_p0;
  logic [31:0] pend_target_p0;
  logic        pend_valid_p0;
  logic [31:0] fetch_count_p0;

  assign redir_req  = bus.jump | bus.branch_taken;
  assign raw_target = bus.jump ? bus.jump_target : bus.branch_target;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign;
  logic err_p0;

  assign misalign     = redir_req & (raw_target[1:0] != 2'b00);
  assign redir        = redir_req & ~misalign;
  assign redir_target = raw_target;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        err_p0 <= 1'b0;
    else if (misalign) err_p0 <= 1'b1;
  end

  assign bus.misalign_err = err_p0;
`else
  assign redir            = redir_req;
  assign redir_target     = raw_target & ~32'h0000_0003;
  assign bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN:  run     = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  assign accept = run & bus.imem_ready & ~bus.stall;

  // A fresh redirect beats a buffered one; the buffer beats sequential flow.
  always_comb begin
    next_pc = pc_p0 + 32'd4;
    if (redir)              next_pc = redir_target;
    else if (pend_valid_p0) next_pc = pend_target_p0;
  end

  // ---- stage p0: architectural PC, pending-redirect flag, retire counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_p0          <= RESET_PC;
      pend_valid_p0  <= 1'b0;
      fetch_count_p0 <= 32'd0;
    end else begin
      if (accept) begin
        pc_p0         <= next_pc;
        pend_valid_p0 <= 1'b0;
      end else if (redir) begin
        pend_valid_p0 <= 1'b1;
      end
      if (bus.fetch_valid) fetch_count_p0 <= fetch_count_p0 + 32'd1;
    end
  end

  // Target storage is qualified by pend_valid_p0, so it needs no reset.
  always_ff @(posedge clock) begin
    if (redir && !accept) pend_target_p0 <= redir_target;
  end

  assign bus.pc_out      = pc_p0;
  assign bus.pc_plus4    = pc_p0 + 32'd4;
  assign bus.imem_req    = run;
  assign bus.if_flush    = redir;
  assign bus.fetch_valid = accept & ~redir & ~pend_valid_p0;
  assign bus.fetch_count = fetch_count_p0;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed test-plan steps then randomized traffic against a behavioural model.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: running flag, PC, pending redirect, counter, sticky error.
  logic        m_run, m_pv, m_err;
  logic [31:0] m_pc, m_pt, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Effective redirect from the raw inputs, expressed with plain arithmetic.
  function automatic void model_redir(input logic br, input logic [31:0] bt, input logic jp,
                                      input logic [31:0] jt, output logic r,
                                      output logic [31:0] t, output logic drop);
    logic [31:0] raw;
    raw = jp ? jt : bt;
`ifdef PC_ALIGN_CHECK_EN
    drop = (jp || br) && (raw % 4 != 0);
    r    = (jp || br) && !drop;
    t    = raw;
`else
    drop = 1'b0;
    r    = jp || br;
    t    = raw - (raw % 4);
`endif
  endfunction

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic rdy);
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = jp;
    bus.jump_target   = jt;
    bus.imem_ready    = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  // One clock: drive, check every output against the model, advance the model.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic rdy);
    logic        r, drop, acc, fv;
    logic [31:0] t;
    drive(st, br, bt, jp, jt, rdy);
    #1;
    model_redir(br, bt, jp, jt, r, t, drop);
    acc = m_run && rdy && !st;
    fv  = acc && !r && !m_pv;
    chk("pc_out",       bus.pc_out,       m_pc);
    chk("pc_plus4",     bus.pc_plus4,     m_pc + 32'd4);
    chk("imem_req",     bus.imem_req,     m_run);
    chk("fetch_valid",  bus.fetch_valid,  fv);
    chk("if_flush",     bus.if_flush,     r);
    chk("fetch_count",  bus.fetch_count,  m_cnt);
    chk("misalign_err", bus.misalign_err, m_err);
    @(posedge clock);
    if (drop) m_err = 1'b1;
    if (acc) begin
      m_pc = r ? t : (m_pv ? m_pt : m_pc + 32'd4);
      m_pv = 1'b0;
    end else if (r) begin
      m_pv = 1'b1;
      m_pt = t;
    end
    if (fv) m_cnt = m_cnt + 32'd1;
    m_run = 1'b1;
    @(negedge clock);
    idle();
    #1;
  endtask

  task automatic go(input logic st, input logic rdy);
    step(st, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  task automatic jump_to(input logic [31:0] a);
    step(1'b0, 1'b0, 32'h0, 1'b1, a, 1'b1);
  endtask

  // Hold reset low for n cycles with random redirect traffic; if_flush must still track it.
  task automatic do_reset(input int n);
    logic        r, drop, br, jp;
    logic [31:0] t, bt, jt;
    reset = 1'b0;
    m_run = 1'b0; m_pv = 1'b0; m_err = 1'b0; m_pc = RPC; m_cnt = 32'd0; m_pt = 32'd0;
    for (int i = 0; i < n; i++) begin
      br = 1'($urandom_range(0, 1));
      jp = 1'($urandom_range(0, 1));
      bt = $urandom;
      jt = $urandom;
      drive(1'($urandom_range(0, 1)), br, bt, jp, jt, 1'b1);
      #1;
      model_redir(br, bt, jp, jt, r, t, drop);
      chk("rst_pc_out",       bus.pc_out,       RPC);
      chk("rst_imem_req",     bus.imem_req,     32'd0);
      chk("rst_fetch_valid",  bus.fetch_valid,  32'd0);
      chk("rst_fetch_count",  bus.fetch_count,  32'd0);
      chk("rst_misalign_err", bus.misalign_err, 32'd0);
      chk("rst_if_flush",     bus.if_flush,     r);
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
    idle();
    #1;
  endtask

  logic [31:0] c0, bt_r, jt_r;

  initial begin
    idle();
    @(negedge clock);

    // Reset and boot
    do_reset(3);
    go(1'b0, 1'b1);
    chk("boot_pc0", bus.pc_out, 32'h0040_0000);
    chk("boot_fv",  bus.fetch_valid, 32'd1);
    go(1'b0, 1'b1);
    chk("boot_pc1", bus.pc_out, 32'h0040_0004);
    go(1'b0, 1'b1);
    chk("boot_pc2", bus.pc_out, 32'h0040_0008);
    go(1'b0, 1'b1);
    chk("boot_cnt", bus.fetch_count, 32'd3);

    // Stall hold
    jump_to(32'h10);
    chk("stall_pc_before", bus.pc_out, 32'h10);
    c0 = m_cnt;
    go(1'b1, 1'b1);
    go(1'b1, 1'b1);
    chk("stall_pc_hold", bus.pc_out, 32'h10);
    chk("stall_cnt",     bus.fetch_count, c0);
    go(1'b0, 1'b1);
    chk("stall_pc_after", bus.pc_out, 32'h14);

    // Taken branch
    jump_to(32'h20);
    step(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    chk("br_pc",  bus.pc_out, 32'h80);
    chk("br_fv",  bus.fetch_valid, 32'd1);

    // Redirects during a memory wait, later one wins
    jump_to(32'h30);
    step(1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0);
    chk("wait_pc_hold", bus.pc_out, 32'h30);
    go(1'b0, 1'b1);
    chk("wait_pc", bus.pc_out, 32'h300);

    // Jump beats branch; PC wraps
    step(1'b0, 1'b1, 32'h500, 1'b1, 32'h400, 1'b1);
    chk("prio_pc", bus.pc_out, 32'h400);
    jump_to(32'hFFFF_FFF8);
    go(1'b0, 1'b1);
    chk("wrap_pc_top", bus.pc_out, 32'hFFFF_FFFC);
    go(1'b0, 1'b1);
    chk("wrap_pc_zero", bus.pc_out, 32'h0);

    // Misaligned jump
    go(1'b0, 1'b1);
    jump_to(32'h103);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc",  bus.pc_out, 32'h8);
    chk("mis_err", bus.misalign_err, 32'd1);
    go(1'b0, 1'b1);
    go(1'b1, 1'b0);
    chk("mis_err_sticky", bus.misalign_err, 32'd1);
`else
    chk("mis_pc",  bus.pc_out, 32'h100);
    chk("mis_err", bus.misalign_err, 32'd0);
`endif

    // Reset with a redirect pending must discard it
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
    do_reset(2);
    go(1'b0, 1'b1);
    chk("rst_mid_pc",  bus.pc_out, RPC);
    chk("rst_mid_err", bus.misalign_err, 32'd0);
    go(1'b0, 1'b1);
    chk("rst_mid_pc1", bus.pc_out, RPC + 32'd4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        bt_r = $urandom;
        jt_r = $urandom;
        if ($urandom_range(0, 1) == 1) bt_r[1:0] = 2'b00;
        if ($urandom_range(0, 1) == 1) jt_r[1:0] = 2'b00;
        step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0), bt_r,
             1'($urandom_range(0, 7) == 0), jt_r, 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage sequencer for the pipelined MIPS core. It owns the program-counter register and chooses each next PC from sequential, branch and jump sources. It holds the PC on hazard stalls and instruction-memory wait states, and buffers a redirect that arrives while the PC cannot move. It also drives the IF/ID flush and valid signals and a retired-fetch counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- stall  in  1  load-use stall from hazard unit; PC must not advance.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- branch_target  in  32  branch destination.
- jump  in  1  jump decoded in ID this cycle.
- jump_target  in  32  jump destination.
- imem_ready  in  1  instruction memory returns data for pc_out this cycle.
- pc_out  out  32  current fetch address, registered.
- pc_plus4  out  32  pc_out + 4, combinational.
- imem_req  out  1  fetch request to instruction memory.
- fetch_valid  out  1  IF/ID must capture the fetched instruction this cycle.
- if_flush  out  1  IF/ID must load a bubble this cycle.
- fetch_count  out  32  number of cycles with fetch_valid=1.
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- FSM states: BOOT and RUN.
  - Reset enters BOOT with imem_req=0.
  - BOOT goes to RUN on the first clock edge after reset deasserts.
  - RUN is held until reset. In RUN, imem_req=1 continuously.
- Redirect: redir = jump | branch_taken. Jump has priority when both are set, so redir_target = jump ? jump_target : branch_target.
- accept = RUN & imem_ready & ~stall. pc_out changes only on an accepted edge.
- Next PC on accept, in priority order:
  - redir_target when redir=1 this cycle;
  - otherwise pend_target when pend_valid=1;
  - otherwise pc_out+4.
- Pending redirect buffer:
  - redir=1 without accept: the buffer loads redir_target and pend_valid is set. A later redirect overwrites an earlier one.
  - accept clears pend_valid.
- if_flush = redir, combinational, in any state. A redirect is valid in BOOT and is buffered.
- fetch_valid = accept & ~redir & ~pend_valid. The wrong-path instruction fetched alongside, or before, a redirect is never delivered.
- fetch_count increments by 1 on every edge where fetch_valid=1. It wraps from 32'hFFFF_FFFF to 0.
- Width rules:
  - All PC arithmetic is 32-bit modulo. PC 32'hFFFF_FFFC plus 4 gives 0.
  - Redirect targets are taken as-is, except for the alignment handling in Configuration.

## Timing
- Reset values: pc_out=RESET_PC, pend_valid=0, fetch_count=0, misalign_err=0, imem_req=0, fetch_valid=0. if_flush follows redir even during reset.
- The first request is issued in the cycle after the first post-reset edge. pc_out=RESET_PC at that point.
- Fetch latency:
  - With imem_ready=1 and stall=0 throughout, pc_out advances by 4 every cycle and fetch_valid=1 every cycle.
  - Throughput is 1 instruction per cycle.
- Stall and imem_ready=0 both hold pc_out, fetch_valid=0 and imem_req=1. Stall takes precedence; there is no separate memory-wait behaviour.
- A redirect applied on an accepted edge gives pc_out=target on the next cycle.
- A redirect during a stall or wait gives pc_out=target on the edge that ends the stall or wait.
- Reset asserted mid-operation clears pend_valid and any buffered target. The FSM returns to BOOT asynchronously.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A redirect with redir_target[1:0] != 0 is dropped: no buffer update, no PC change, if_flush=0.
  - misalign_err sets on the next edge and stays high until reset.
- PC_ALIGN_CHECK_EN undefined:
  - redir_target[1:0] is forced to 2'b00 before use.
  - misalign_err is constant 0.

## Test plan
- Reset and boot: RESET_PC=32'h0040_0000, reset low for 3 cycles then high, imem_ready=1. Required: pc_out=0x00400000 with imem_req=0 during reset. Then the sequence 0x00400000, 0x00400004, 0x00400008 with fetch_valid=1, and fetch_count=3 after three fetches.
- Stall hold: at pc_out=0x10, stall=1 for 2 cycles. Required: pc_out stays 0x10, fetch_valid=0, fetch_count unchanged. The next cycle gives pc_out=0x14.
- Taken branch: at pc_out=0x20, branch_taken=1 with branch_target=0x80 for one cycle. Required: if_flush=1 and fetch_valid=0 that cycle. The next cycle gives pc_out=0x80 and fetch_valid=1.
- Redirect during memory wait: imem_ready=0 at pc_out=0x30, jump=1 with jump_target=0x200 for one cycle, then branch_taken=1 with branch_target=0x300 one cycle later, then imem_ready=1. Required: pc_out=0x300 after the ready edge, and no fetch_valid before it.
- Jump versus branch in the same cycle: jump_target=0x400 and branch_target=0x500. Required: pc_out=0x400. Also wrap: pc_out=0xFFFFFFFC advances to 0x00000000.
- Misaligned jump with the macro defined: jump_target=0x103. Required: if_flush=0, pc_out continues +4, and misalign_err=1 held until reset. With the macro undefined, the same stimulus gives pc_out=0x100.
